// File: rtl/median_ctrl_pkg.sv
// Shared types and width helpers for the median filter frame controller.
// Widths are derived from the frame geometry so every counter can hold its terminal value.
package median_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Bits needed to hold every value in 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    // The bypass geometry is the larger one, so it sizes the column counter.
    function automatic int out_col_width(input int col_num);
        return cnt_width(col_num);
    endfunction

    function automatic int out_num_width(input int col_num, input int row_num);
        return cnt_width(col_num * row_num);
    endfunction

endpackage

// File: rtl/median_pos_cnt.sv
// Output raster position tracker: counts accepted output pixels and reports
// column/row plus start-of-frame and end-of-line markers for the next pixel.
module median_pos_cnt
    import median_ctrl_pkg::*;
#(
    parameter int COL_W = 4,
    parameter int ROW_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             sclk,
    input  logic             rst_n,
    input  logic [COL_W-1:0] out_col,
    input  logic             strobe,
    input  logic             clear,
    output logic [CNT_W-1:0] out_cnt,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             sof,
    output logic             eol
);

    assign sof = (out_cnt == '0);
    assign eol = (col == out_col - 1'b1);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge sclk) begin
        if (!rst_n || clear) begin
            out_cnt <= '0;
            col     <= '0;
            row     <= '0;
        end else if (strobe) begin
            out_cnt <= out_cnt + 1'b1;
            if (eol) begin
                col <= '0;
                row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/median_filter_ctrl.sv
// Frame sequencer around the 3x3 median filter: paces a raster source into the
// filter, collects and tags its output, and reports frame completion or timeout.
module median_filter_ctrl
    import median_ctrl_pkg::*;
#(
    parameter int COL_NUM = 1024,
    parameter int ROW_NUM = 768,
    parameter int GAP     = 0,
    parameter int TIMEOUT = 4096
) (
    input  logic       sclk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       bypass,
    input  logic [7:0] src_data,
    input  logic       src_valid,
    output logic       src_ready,
    output logic [7:0] flt_data,
    output logic       flt_flag,
    input  logic [7:0] flt_tx_data,
    input  logic       flt_po_flag,
    output logic [7:0] dst_data,
    output logic       dst_valid,
    output logic       dst_sof,
    output logic       dst_eol,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int PIX_NUM = COL_NUM * ROW_NUM;
    localparam int CNT_W   = out_num_width(COL_NUM, ROW_NUM);
    localparam int COL_W   = out_col_width(COL_NUM);
    localparam int ROW_W   = cnt_width(ROW_NUM);
    localparam int TO_W    = cnt_width(TIMEOUT);

    localparam logic [CNT_W-1:0] PIX_END  = CNT_W'(PIX_NUM);
    localparam logic [CNT_W-1:0] PIX_LAST = CNT_W'(PIX_NUM - 1);
    localparam logic [CNT_W-1:0] FLT_NUM  = CNT_W'((COL_NUM - 2) * (ROW_NUM - 2));
    localparam logic [COL_W-1:0] FLT_COL  = COL_W'(COL_NUM - 2);
    localparam logic [COL_W-1:0] BYP_COL  = COL_W'(COL_NUM);
    localparam logic [ROW_W-1:0] FLT_ROW  = ROW_W'(ROW_NUM - 2);
    localparam logic [ROW_W-1:0] BYP_ROW  = ROW_W'(ROW_NUM);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [7:0]       GAP_LD   = 8'(GAP);

    state_t           state_q, state_d;
    logic             bypass_q;
    logic             err_q;
    logic [CNT_W-1:0] in_cnt_q;
    logic [7:0]       gap_q;
    logic [TO_W-1:0]  to_q;
    logic             to_hit;

    logic [COL_W-1:0] out_col;
    logic [ROW_W-1:0] out_row;
    logic [CNT_W-1:0] out_num;
    logic [CNT_W-1:0] out_cnt;
    logic [COL_W-1:0] pos_col;
    logic [ROW_W-1:0] pos_row;
    logic             pos_sof;
    logic             pos_eol;
    logic             pos_clear;
    logic             out_full;
    logic             xfer;
    logic             out_strobe;

    assign out_col = bypass_q ? BYP_COL : FLT_COL;
    assign out_row = bypass_q ? BYP_ROW : FLT_ROW;
    assign out_num = bypass_q ? PIX_END : FLT_NUM;

    assign src_ready = (state_q == ST_FEED) && (gap_q == 8'd0) && (in_cnt_q != PIX_END);
    assign xfer      = src_valid && src_ready;
    // Row and pixel count reach their ends together; requiring both guards the geometry.
    assign out_full  = (out_cnt == out_num) && (pos_row == out_row);

    assign out_strobe = (state_q inside {ST_FEED, ST_DRAIN}) && !out_full
                        && (bypass_q ? xfer : flt_po_flag);
    assign pos_clear  = (state_q == ST_IDLE) && start;

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);
    assign err  = done && err_q;

    median_pos_cnt #(
        .COL_W (COL_W),
        .ROW_W (ROW_W),
        .CNT_W (CNT_W)
    ) u_pos_cnt (
        .sclk    (sclk),
        .rst_n   (rst_n),
        .out_col (out_col),
        .strobe  (out_strobe),
        .clear   (pos_clear),
        .out_cnt (out_cnt),
        .col     (pos_col),
        .row     (pos_row),
        .sof     (pos_sof),
        .eol     (pos_eol)
    );

    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        to_hit  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_FEED;
            end
            ST_FEED: begin
                if (xfer && (in_cnt_q == PIX_LAST)) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (out_full) begin
                    state_d = ST_DONE;
                end else if (!out_strobe && (to_q == TO_LAST)) begin
                    to_hit  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bypass_q  <= 1'b0;
            err_q     <= 1'b0;
            in_cnt_q  <= '0;
            gap_q     <= '0;
            to_q      <= '0;
            flt_data  <= '0;
            flt_flag  <= 1'b0;
            dst_data  <= '0;
            dst_valid <= 1'b0;
            dst_sof   <= 1'b0;
            dst_eol   <= 1'b0;
        end else begin
            state_q <= state_d;

            // The filter is fed in bypass mode too so its line buffers stay primed.
            flt_flag <= xfer;
            if (xfer) flt_data <= src_data;

            dst_valid <= out_strobe;
            dst_sof   <= out_strobe && pos_sof;
            dst_eol   <= out_strobe && pos_eol;
            if (out_strobe) dst_data <= bypass_q ? src_data : flt_tx_data;

            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        bypass_q <= bypass;
                        err_q    <= 1'b0;
                        in_cnt_q <= '0;
                        gap_q    <= '0;
                        to_q     <= '0;
                    end
                end
                ST_FEED: begin
                    to_q <= '0;
                    if (xfer) begin
                        in_cnt_q <= in_cnt_q + 1'b1;
                        gap_q    <= GAP_LD;
                    end else if (gap_q != 8'd0) begin
                        gap_q <= gap_q - 8'd1;
                    end
                end
                ST_DRAIN: begin
                    to_q <= out_strobe ? '0 : to_q + 1'b1;
                    if (to_hit) err_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_median_filter_ctrl.sv
// Self-checking bench: a behavioural 3x3 median filter model sits on the filter
// port, and captured streams are compared with values derived from frame geometry.
module tb_median_filter_ctrl;

    localparam int COLS = 8;
    localparam int ROWS = 6;
    localparam int NPIX = COLS * ROWS;

    logic       sclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       start_g = 1'b0;
    logic       bypass = 1'b0;
    logic [7:0] src_data = '0;
    logic       src_valid = 1'b0;
    logic [7:0] flt_tx_data;
    logic       flt_po_flag;

    logic       src_ready, flt_flag, dst_valid, dst_sof, dst_eol, busy, done, err;
    logic [7:0] flt_data, dst_data;
    logic       g_src_ready, g_flt_flag, g_dst_valid, g_dst_sof, g_dst_eol, g_busy, g_done, g_err;
    logic [7:0] g_flt_data, g_dst_data;

    always #5 sclk = ~sclk;

    median_filter_ctrl #(.COL_NUM(COLS), .ROW_NUM(ROWS), .GAP(0), .TIMEOUT(64)) u_dut (
        .sclk(sclk), .rst_n(rst_n), .start(start), .bypass(bypass),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .flt_data(flt_data), .flt_flag(flt_flag),
        .flt_tx_data(flt_tx_data), .flt_po_flag(flt_po_flag),
        .dst_data(dst_data), .dst_valid(dst_valid), .dst_sof(dst_sof), .dst_eol(dst_eol),
        .busy(busy), .done(done), .err(err)
    );

    median_filter_ctrl #(.COL_NUM(COLS), .ROW_NUM(ROWS), .GAP(3), .TIMEOUT(64)) u_dut_gap (
        .sclk(sclk), .rst_n(rst_n), .start(start_g), .bypass(bypass),
        .src_data(src_data), .src_valid(src_valid), .src_ready(g_src_ready),
        .flt_data(g_flt_data), .flt_flag(g_flt_flag),
        .flt_tx_data(8'd0), .flt_po_flag(1'b0),
        .dst_data(g_dst_data), .dst_valid(g_dst_valid), .dst_sof(g_dst_sof), .dst_eol(g_dst_eol),
        .busy(g_busy), .done(g_done), .err(g_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- behavioural filter model ----------------
    int f_mode = 0;      // 0 normal, 1 emit only 20 after the last input, 2 normal then 3 stray pulses
    int f_cnt = 0;
    int f_emit = 0;
    int po_inject = 0;
    int pix[NPIX];
    int pend[$];

    function automatic int median9(input int w[9]);
        int t[9];
        int tmp;
        t = w;
        for (int i = 0; i < 9; i++)
            for (int j = 0; j < 8 - i; j++)
                if (t[j] > t[j+1]) begin
                    tmp = t[j]; t[j] = t[j+1]; t[j+1] = tmp;
                end
        return t[4];
    endfunction

    initial begin
        int r, c;
        int win[9];
        flt_po_flag = 1'b0;
        flt_tx_data = '0;
        forever begin
            @(negedge sclk);
            flt_po_flag = 1'b0;
            if (flt_flag && f_cnt < NPIX) begin
                pix[f_cnt] = int'(flt_data);
                r = f_cnt / COLS;
                c = f_cnt % COLS;
                if (r >= 2 && c >= 2) begin
                    for (int dr = 0; dr < 3; dr++)
                        for (int dc = 0; dc < 3; dc++)
                            win[dr*3+dc] = pix[(r-2+dr)*COLS + (c-2+dc)];
                    pend.push_back(median9(win));
                end
                f_cnt++;
            end
            if (po_inject > 0) begin
                flt_po_flag = 1'b1;
                flt_tx_data = 8'hEE;
                po_inject--;
            end else if (pend.size() > 0 && (f_mode != 1 || (f_cnt == NPIX && f_emit < 20))) begin
                flt_tx_data = 8'(pend.pop_front());
                flt_po_flag = 1'b1;
                f_emit++;
                if (f_mode == 2 && f_emit == 24) po_inject = 3;
            end
        end
    end

    // ---------------- monitor (mid-cycle sampling) ----------------
    int smp = 0;
    int m_xf_smp[$], m_po_smp[$], m_dv_data[$], m_dv_smp[$];
    bit m_dv_sof[$], m_dv_eol[$];
    int m_ff_cnt = 0, m_done_cnt = 0, m_done_smp = 0, m_err_cnt = 0, m_err_alone = 0;
    int g_xf_smp[$], g_dv_data[$], g_dv_smp[$];
    int g_done_cnt = 0;

    initial begin
        forever begin
            @(negedge sclk);
            #2;
            smp++;
            if (src_valid && src_ready) m_xf_smp.push_back(smp);
            if (flt_flag) m_ff_cnt++;
            if (flt_po_flag) m_po_smp.push_back(smp);
            if (dst_valid) begin
                m_dv_data.push_back(int'(dst_data));
                m_dv_smp.push_back(smp);
                m_dv_sof.push_back(dst_sof);
                m_dv_eol.push_back(dst_eol);
            end
            if (done) begin
                m_done_cnt++;
                m_done_smp = smp;
            end
            if (err) begin
                if (done) m_err_cnt++;
                else m_err_alone++;
            end
            if (src_valid && g_src_ready) g_xf_smp.push_back(smp);
            if (g_dst_valid) begin
                g_dv_data.push_back(int'(g_dst_data));
                g_dv_smp.push_back(smp);
            end
            if (g_done) g_done_cnt++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic new_frame();
        @(negedge sclk);
        #5;
        m_xf_smp.delete(); m_po_smp.delete(); m_dv_data.delete(); m_dv_smp.delete();
        m_dv_sof.delete(); m_dv_eol.delete();
        m_ff_cnt = 0; m_done_cnt = 0; m_done_smp = 0; m_err_cnt = 0; m_err_alone = 0;
        g_xf_smp.delete(); g_dv_data.delete(); g_dv_smp.delete(); g_done_cnt = 0;
        f_cnt = 0; f_emit = 0; po_inject = 0; pend.delete();
    endtask

    task automatic start_frame(input bit byp, input bit g);
        @(negedge sclk);
        bypass = byp;
        if (g) start_g = 1'b1;
        else   start = 1'b1;
        @(negedge sclk);
        start = 1'b0;
        start_g = 1'b0;
        bypass = 1'b0;
    endtask

    task automatic feed(input bit g, input bit rnd, input int rst_at, input int pulse_at);
        int idx = 0;
        int cyc = 0;
        bit rdy;
        bit pulsed = 1'b0;
        while (idx < NPIX && cyc < 3000) begin
            @(negedge sclk);
            start = 1'b0;
            if (idx == rst_at) begin
                src_valid = 1'b0;
                rst_n = 1'b0;
                return;
            end
            if (idx == pulse_at && !pulsed) begin
                start = 1'b1;
                pulsed = 1'b1;
            end
            src_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            src_data = 8'(idx);
            #1;
            rdy = g ? g_src_ready : src_ready;
            if (src_valid && rdy) idx++;
            cyc++;
        end
        @(negedge sclk);
        start = 1'b0;
        src_valid = 1'b0;
        check(g ? "g_feed_all" : "feed_all", idx, NPIX);
    endtask

    task automatic wait_done(input bit g, input int budget);
        int n = 0;
        while (((g ? g_done_cnt : m_done_cnt) == 0) && n < budget) begin
            @(negedge sclk);
            #3;
            n++;
        end
        check(g ? "g_done_seen" : "done_seen", ((g ? g_done_cnt : m_done_cnt) > 0) ? 1 : 0, 1);
        repeat (3) @(negedge sclk);
        #3;
    endtask

    task automatic check_frame(input string name, input bit byp, input int exp_n, input int ocol);
        int bad_data = 0, bad_lat = 0, bad_eol = 0, bad_sof = 0;
        int n, exp_d;
        check({name, "_count"}, m_dv_data.size(), exp_n);
        n = (m_dv_data.size() < exp_n) ? m_dv_data.size() : exp_n;
        for (int k = 0; k < n; k++) begin
            exp_d = byp ? (k % 256) : ((k / ocol) + 1) * COLS + (k % ocol) + 1;
            if (m_dv_data[k] != exp_d) bad_data++;
            if (byp) begin
                if (k >= m_xf_smp.size() || m_dv_smp[k] != m_xf_smp[k] + 1) bad_lat++;
            end else begin
                if (k >= m_po_smp.size() || m_dv_smp[k] != m_po_smp[k] + 1) bad_lat++;
            end
            if (m_dv_eol[k] != ((k + 1) % ocol == 0)) bad_eol++;
            if (m_dv_sof[k] != (k == 0)) bad_sof++;
        end
        check({name, "_data_bad"}, bad_data, 0);
        check({name, "_latency_bad"}, bad_lat, 0);
        check({name, "_eol_bad"}, bad_eol, 0);
        check({name, "_sof_bad"}, bad_sof, 0);
    endtask

    function automatic int outs_zero();
        return int'({src_ready, flt_data, flt_flag, dst_data, dst_valid, dst_sof, dst_eol, busy, done, err});
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        int min_gap, bad;

        repeat (3) @(negedge sclk);
        #3;
        check("reset_outputs", outs_zero(), 0);
        check("reset_gap_dut", int'({g_src_ready, g_flt_data, g_flt_flag, g_dst_data, g_dst_valid,
                                     g_dst_sof, g_dst_eol, g_busy, g_done, g_err}), 0);
        @(negedge sclk);
        rst_n = 1'b1;

        // 1: filter-mode frame
        new_frame();
        f_mode = 0;
        start_frame(1'b0, 1'b0);
        check("busy_after_start", int'(busy), 1);
        feed(1'b0, 1'b0, -1, -1);
        wait_done(1'b0, 200);
        check("t1_flt_flag_cnt", m_ff_cnt, NPIX);
        check_frame("t1", 1'b0, 24, COLS - 2);
        check("t1_done_cnt", m_done_cnt, 1);
        check("t1_err_cnt", m_err_cnt + m_err_alone, 0);
        check("t1_idle_after", int'(busy), 0);

        // 2: bypass frame
        new_frame();
        start_frame(1'b1, 1'b0);
        feed(1'b0, 1'b0, -1, -1);
        wait_done(1'b0, 200);
        check_frame("t2", 1'b1, NPIX, COLS);
        check("t2_err_cnt", m_err_cnt + m_err_alone, 0);

        // 3: pacing with GAP=3 and a random source
        new_frame();
        start_frame(1'b1, 1'b1);
        feed(1'b1, 1'b1, -1, -1);
        wait_done(1'b1, 200);
        check("t3_accepted", g_xf_smp.size(), NPIX);
        min_gap = 1000;
        for (int k = 1; k < g_xf_smp.size(); k++)
            if (g_xf_smp[k] - g_xf_smp[k-1] < min_gap) min_gap = g_xf_smp[k] - g_xf_smp[k-1];
        check("t3_min_spacing_ok", (min_gap >= 4) ? 1 : 0, 1);
        check("t3_out_count", g_dv_data.size(), NPIX);
        bad = 0;
        for (int k = 0; k < g_dv_data.size(); k++)
            if (g_dv_data[k] != k || k >= g_xf_smp.size() || g_dv_smp[k] != g_xf_smp[k] + 1) bad++;
        check("t3_order_bad", bad, 0);

        // 4: timeout with a stubbed filter emitting only 20 outputs
        new_frame();
        f_mode = 1;
        start_frame(1'b0, 1'b0);
        feed(1'b0, 1'b0, -1, -1);
        wait_done(1'b0, 300);
        check_frame("t4", 1'b0, 20, COLS - 2);
        check("t4_err_with_done", m_err_cnt, 1);
        check("t4_err_alone", m_err_alone, 0);
        check("t4_done_delay", (m_dv_smp.size() >= 20) ? m_done_smp - m_dv_smp[19] : -1, 64);

        // 5: reset mid-frame, then a clean frame with a stray start during FEED
        new_frame();
        f_mode = 0;
        start_frame(1'b0, 1'b0);
        feed(1'b0, 1'b0, 30, -1);
        @(negedge sclk);
        #3;
        check("t5_reset_outputs", outs_zero(), 0);
        @(negedge sclk);
        rst_n = 1'b1;
        repeat (4) @(negedge sclk);
        #3;
        check("t5_no_done", m_done_cnt, 0);
        check("t5_idle", int'(busy), 0);
        new_frame();
        start_frame(1'b0, 1'b0);
        feed(1'b0, 1'b0, -1, 10);
        wait_done(1'b0, 200);
        check_frame("t5", 1'b0, 24, COLS - 2);
        check("t5_done_cnt", m_done_cnt, 1);

        // 6: stray filter strobes in IDLE and after the last output; start during DONE
        new_frame();
        f_mode = 2;
        po_inject = 2;
        repeat (4) @(negedge sclk);
        #3;
        check("t6_idle_strobes", m_dv_data.size(), 0);
        m_po_smp.delete();
        start_frame(1'b0, 1'b0);
        feed(1'b0, 1'b0, -1, -1);
        bad = 0;
        while (m_done_cnt == 0 && bad < 200) begin
            @(negedge sclk);
            #3;
            bad++;
        end
        check("t6_done_seen", m_done_cnt, 1);
        start = 1'b1;
        @(negedge sclk);
        start = 1'b0;
        repeat (4) @(negedge sclk);
        #3;
        check("t6_start_in_done_ignored", int'(busy), 0);
        check_frame("t6", 1'b0, 24, COLS - 2);
        check("t6_done_cnt", m_done_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got %0d expected %0d", 1, 0);
        $fatal(1, "bench time limit reached");
    end

endmodule

// File: doc/median_filter_ctrl.md
# median_filter_ctrl

Frame-level sequencer for the 3x3 median filter datapath. Accepts a raster pixel stream from an upstream source with a valid/ready handshake and paces it into the filter's `rx_data`/`pi_flag` port. Collects `tx_data`/`po_flag` back from the filter, tags output pixels with start-of-frame and end-of-line markers, and reports frame completion or timeout. A bypass mode routes pixels around the filter unchanged.

## Interface
- `COL_NUM`, 1024: input pixels per row.
- `ROW_NUM`, 768: input rows per frame.
- `GAP`, 0: idle cycles forced between consecutive accepted pixels (0..255).
- `TIMEOUT`, 4096: maximum DRAIN cycles with no output pixel before abort.
- `sclk` in 1: single clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: one-cycle pulse; begins a frame when IDLE.
- `bypass` in 1: sampled on an accepted `start`; 1 = route around the filter.
- `src_data` in 8: source pixel.
- `src_valid` in 1: source pixel valid.
- `src_ready` out 1: controller can accept a pixel.
- `flt_data` out 8: to filter `rx_data`.
- `flt_flag` out 1: to filter `pi_flag`.
- `flt_tx_data` in 8: from filter `tx_data`.
- `flt_po_flag` in 1: from filter `po_flag`.
- `dst_data` out 8: output pixel.
- `dst_valid` out 1: output pixel strobe. There is no backpressure.
- `dst_sof` out 1: set with the first output pixel of a frame.
- `dst_eol` out 1: set with the last pixel of each output row.
- `busy` out 1: high in any state except IDLE.
- `done` out 1: one-cycle pulse at the end of a frame.
- `err` out 1: one-cycle pulse, coincident with `done`, when the frame ends by timeout.

## Operation
- **Output frame geometry**
  - Filter mode: OUT_COL = COL_NUM-2, OUT_ROW = ROW_NUM-2.
  - Bypass mode: OUT_COL = COL_NUM, OUT_ROW = ROW_NUM.
  - OUT_NUM = OUT_COL*OUT_ROW.
- **FSM states:** IDLE, FEED, DRAIN, DONE.
- **IDLE**
  - `src_ready`=0.
  - `start`=1 latches `bypass`, clears all counters and moves to FEED.
  - `flt_po_flag` is ignored in this state.
- **FEED**
  - `src_ready`=1 when the gap counter is 0 and in_cnt < COL_NUM*ROW_NUM.
  - Transfer condition: `src_valid & src_ready`.
  - On a transfer:
    - in_cnt increments.
    - The gap counter loads GAP.
    - `flt_data`<=`src_data`; `flt_flag`<=1 next cycle, otherwise 0. This happens in bypass mode too, so the filter stays fed.
  - When in_cnt reaches COL_NUM*ROW_NUM, move to DRAIN.
- **DRAIN**
  - `src_ready`=0.
  - Move to DONE when out_cnt == OUT_NUM.
  - The timeout counter increments each cycle and clears on every `dst_valid`.
  - If the timeout counter reaches TIMEOUT, flag err and move to DONE.
- **DONE**
  - Lasts one cycle: `done`=1, plus `err`=1 if the frame timed out.
  - Then move to IDLE.
- **Output path** (active in FEED and DRAIN)
  - Filter mode: `dst_valid`<=`flt_po_flag`, `dst_data`<=`flt_tx_data`.
  - Bypass mode: `dst_valid`<=transfer, `dst_data`<=`src_data`.
  - Output strobes are dropped once out_cnt == OUT_NUM.
- **Position counters**
  - A column counter wraps at OUT_COL-1 and then increments the row counter.
  - `dst_eol` is set when col == OUT_COL-1.
  - `dst_sof` is set when out_cnt == 0.
- **Boundary conditions**
  - `start` while busy is ignored.
  - `start` coincident with the DONE cycle is ignored.
  - `src_valid` in IDLE, DRAIN or DONE is not accepted.
  - A filter output arriving in the same cycle as the last input is counted normally.
  - `rst_n`=0 mid-frame returns to IDLE the next edge. All counters clear. No `done` is issued.
- **Counter widths:** `$clog2(COL_NUM*ROW_NUM+1)` for in_cnt and out_cnt; `$clog2(TIMEOUT+1)` for the timeout counter.

## Timing
- **Reset values:** every output is 0 after a reset edge: `src_ready`, `flt_data`, `flt_flag`, `dst_data`, `dst_valid`, `dst_sof`, `dst_eol`, `busy`, `done`, `err`. The state is IDLE.
- **Start:** `start` at edge t gives `busy`=1 and `src_ready` eligible from t+1.
- **Input path:** a transfer at edge t gives `flt_flag`/`flt_data` at t+1.
  - With GAP=g, the next `src_ready` comes at t+1+g.
- **Bypass latency:** `dst_valid` at t+1 after the transfer.
- **Filter mode latency:** `dst_valid` one cycle after `flt_po_flag`.
- **DRAIN:** the final `dst_valid` at edge t gives DONE at t+1 and `done` visible at t+1. The state is IDLE at t+2.

## Structure
- **Package `median_ctrl_pkg`:**
  - State enum (2-bit).
  - Constant functions for the OUT_COL/OUT_NUM widths.
- **Sub-module `median_pos_cnt`:**
  - Inputs: `out_col`, `strobe`, `clear`.
  - Outputs: `out_cnt`, `col`, `row`, `sof`, `eol`.
  - The FSM, pacing and muxing stay in the top module.

## Test plan
Bench parameters: COL_NUM=8, ROW_NUM=6, GAP=0, TIMEOUT=64, with the real `median_filter` attached unless stated otherwise.
1. **Filter-mode frame:** constant-valid source with pixel value = index%256 -> 48 `flt_flag` pulses, 24 `dst_valid`, `dst_eol` every 6th pixel, one `dst_sof`, `done`=1 with `err`=0.
2. **Bypass frame:** `bypass`=1 -> 48 `dst_valid` with `dst_data` equal to the inputs in order, each one cycle after its transfer, `dst_eol` every 8th pixel.
3. **Pacing and stalls:** GAP=3 with random `src_valid` -> accepted pixels are at least 4 cycles apart, no pixel lost or duplicated, total 48.
4. **Timeout:** filter model stubbed to emit only 20 `po_flag` -> `done` and `err` pulse together 64 cycles after the 20th output.
5. **Control robustness:** `start` during FEED is ignored; `rst_n` low at input pixel 30 -> IDLE next cycle, all outputs 0, no `done`; the next `start` runs a clean frame of 24 outputs.
6. **Dropped strobes:** extra `flt_po_flag` pulses during IDLE or after the 24th output -> no `dst_valid`, out_cnt stays 24.
